// File: rtl/version_beacon_tx.sv
// Serialises the build-identification constants into a 13-byte frame on a
// byte-wide valid/ready stream, on request and/or on a periodic beacon.
module version_beacon_tx #(
  parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
  parameter logic [7:0]  VER_MAJOR     = 8'd0,
  parameter logic [7:0]  VER_MINOR     = 8'd0,
  parameter logic [7:0]  VER_PATCH     = 8'd0,
  parameter logic [7:0]  VER_BUILD     = 8'd0,
  parameter logic [15:0] VER_YEAR      = 16'h0000,
  parameter logic [7:0]  VER_MONTH     = 8'h00,
  parameter logic [7:0]  VER_DAY       = 8'h00,
  parameter logic [7:0]  VER_HOUR      = 8'h00,
  parameter logic [7:0]  VER_MINUTE    = 8'h00,
  parameter logic [7:0]  VER_SECOND    = 8'h00,
  parameter int unsigned BEACON_PERIOD = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        busy_o,
  output logic        frame_done_o,
  output logic [15:0] frame_count_o
);

  // Wrapping 8-bit sum of bytes 1..11; CHK makes bytes 1..12 sum to zero.
  localparam logic [7:0] PAYLOAD_SUM = VER_MAJOR + VER_MINOR + VER_PATCH + VER_BUILD
                                     + VER_YEAR[15:8] + VER_YEAR[7:0] + VER_MONTH
                                     + VER_DAY + VER_HOUR + VER_MINUTE + VER_SECOND;
  localparam logic [7:0]  CHK         = 8'h00 - PAYLOAD_SUM;
  localparam logic [31:0] BEACON_LAST = BEACON_PERIOD - 1;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        pending_q, pending_d;
  logic [31:0] beacon_cnt_q;
  logic [15:0] frame_cnt_q;
  logic        beacon_tick;
  logic        trig_ev;

  function automatic logic [7:0] frame_byte(input logic [3:0] idx);
    case (idx)
      4'd0:    frame_byte = SYNC_BYTE;
      4'd1:    frame_byte = VER_MAJOR;
      4'd2:    frame_byte = VER_MINOR;
      4'd3:    frame_byte = VER_PATCH;
      4'd4:    frame_byte = VER_BUILD;
      4'd5:    frame_byte = VER_YEAR[15:8];
      4'd6:    frame_byte = VER_YEAR[7:0];
      4'd7:    frame_byte = VER_MONTH;
      4'd8:    frame_byte = VER_DAY;
      4'd9:    frame_byte = VER_HOUR;
      4'd10:   frame_byte = VER_MINUTE;
      4'd11:   frame_byte = VER_SECOND;
      4'd12:   frame_byte = CHK;
      default: frame_byte = 8'h00;
    endcase
  endfunction

  assign beacon_tick = (BEACON_PERIOD != 0) && (beacon_cnt_q == BEACON_LAST);
  assign trig_ev     = req_i | beacon_tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      beacon_cnt_q <= 32'd0;
    end else if (BEACON_PERIOD != 0) begin
      beacon_cnt_q <= beacon_tick ? 32'd0 : beacon_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= 4'd0;
      pending_q   <= 1'b0;
      frame_cnt_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      if (state_q == DONE) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    case (state_q)
      IDLE: begin
        if (trig_ev || pending_q) begin
          state_d   = SEND;
          idx_d     = 4'd0;
          pending_d = 1'b0;
        end
      end
      SEND: begin
        // Any number of triggers during a frame collapse into one follow-up.
        if (trig_ev) pending_d = 1'b1;
        if (tx_ready_i) begin
          if (idx_q == 4'd12) state_d = DONE;
          else                idx_d   = idx_q + 4'd1;
        end
      end
      DONE: begin
        if (trig_ev || pending_q) begin
          state_d   = SEND;
          idx_d     = 4'd0;
          pending_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_valid_o    = (state_q == SEND);
  assign tx_data_o     = (state_q == SEND) ? frame_byte(idx_q) : 8'h00;
  assign busy_o        = (state_q != IDLE);
  assign frame_done_o  = (state_q == DONE);
  assign frame_count_o = frame_cnt_q;

endmodule

// File: tb/tb_version_beacon_tx.sv
// Directed bench for version_beacon_tx: one request-driven instance and one
// beacon-driven instance sharing a clock.
module tb_version_beacon_tx;

  logic        clk;
  logic        rst, req, rdy;
  logic [7:0]  data;
  logic        valid, busy, done;
  logic [15:0] count;

  logic        rst_b, req_b, rdy_b;
  logic [7:0]  data_b;
  logic        valid_b, busy_b, done_b;
  logic [15:0] count_b;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_b [13] = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h35, 8'h20, 8'h25,
                             8'h11, 8'h05, 8'h13, 8'h55, 8'h09, 8'hFF};

  version_beacon_tx #(
    .VER_BUILD(8'd53), .VER_YEAR(16'h2025), .VER_MONTH(8'h11), .VER_DAY(8'h05),
    .VER_HOUR(8'h13), .VER_MINUTE(8'h55), .VER_SECOND(8'h09), .BEACON_PERIOD(0)
  ) u_dut (
    .clk(clk), .rst(rst), .req_i(req), .tx_data_o(data), .tx_valid_o(valid),
    .tx_ready_i(rdy), .busy_o(busy), .frame_done_o(done), .frame_count_o(count)
  );

  version_beacon_tx #(
    .VER_BUILD(8'd53), .VER_YEAR(16'h2025), .VER_MONTH(8'h11), .VER_DAY(8'h05),
    .VER_HOUR(8'h13), .VER_MINUTE(8'h55), .VER_SECOND(8'h09), .BEACON_PERIOD(100)
  ) u_bcn (
    .clk(clk), .rst(rst_b), .req_i(req_b), .tx_data_o(data_b), .tx_valid_o(valid_b),
    .tx_ready_i(rdy_b), .busy_o(busy_b), .frame_done_o(done_b), .frame_count_o(count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Frame already started: checks all 13 bytes with ready high, ends in DONE.
  task automatic send_bytes(input string tag, input logic [12:0] req_at);
    for (int i = 0; i < 13; i++) begin
      req = req_at[i];
      check($sformatf("%s_valid%0d", tag, i), 32'(valid), 1);
      check($sformatf("%s_byte%0d", tag, i), 32'(data), 32'(exp_b[i]));
      tick();
    end
    req = 1'b0;
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_done_valid"}, 32'(valid), 0);
    check({tag, "_done_busy"}, 32'(busy), 1);
  endtask

  initial begin
    logic [31:0] pat;
    int idx, cyc, nframes;
    rst = 1'b1; req = 1'b0; rdy = 1'b1;
    rst_b = 1'b1; req_b = 1'b0; rdy_b = 1'b1;
    pat = 32'hA5C3_96E1;

    // Reset values
    tick(); tick();
    check("rst_valid", 32'(valid), 0);
    check("rst_data", 32'(data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_count", 32'(count), 0);
    rst = 1'b0;
    tick();
    check("idle_valid", 32'(valid), 0);

    // Basic frame, one cycle latency from the request
    req = 1'b1;
    tick();
    send_bytes("basic", 13'd0);
    tick();
    check("basic_done_clear", 32'(done), 0);
    check("basic_idle_busy", 32'(busy), 0);
    check("basic_count", 32'(count), 1);

    // Backpressure: data must track the index that only advances on handshake
    req = 1'b1;
    tick();
    req = 1'b0;
    idx = 0; cyc = 0;
    while (idx < 13 && cyc < 200) begin
      rdy = pat[cyc % 32];
      check($sformatf("bp_valid_c%0d", cyc), 32'(valid), 1);
      check($sformatf("bp_byte_c%0d", cyc), 32'(data), 32'(exp_b[idx]));
      if (rdy) idx++;
      tick();
      cyc++;
    end
    rdy = 1'b1;
    check("bp_len", 32'(idx), 13);
    check("bp_done", 32'(done), 1);
    tick();
    check("bp_count", 32'(count), 2);

    // Three requests during a frame queue exactly one more frame
    req = 1'b1;
    tick();
    send_bytes("q1", 13'b0_0010_0100_1000);
    tick();
    check("q2_start_valid", 32'(valid), 1);
    check("q2_start_count", 32'(count), 3);
    send_bytes("q2", 13'd0);
    tick();
    check("q_end_valid", 32'(valid), 0);
    check("q_end_count", 32'(count), 4);
    tick(); tick();
    check("q_no_extra", 32'(busy), 0);

    // Reset while byte 6 is on the bus
    req = 1'b1;
    tick();
    req = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("mid_byte6", 32'(data), 32'(exp_b[6]));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_valid", 32'(valid), 0);
    check("mid_count", 32'(count), 0);
    check("mid_done", 32'(done), 0);
    tick();
    check("mid_done2", 32'(done), 0);
    check("mid_idle", 32'(valid), 0);
    req = 1'b1;
    tick();
    send_bytes("post", 13'd0);
    tick();
    check("post_count", 32'(count), 1);

    // Frame counter wraps
    force u_dut.frame_cnt_q = 16'hFFFF;
    tick();
    release u_dut.frame_cnt_q;
    check("wrap_pre", 32'(count), 32'hFFFF);
    req = 1'b1;
    tick();
    send_bytes("wrap", 13'd0);
    tick();
    check("wrap_count", 32'(count), 0);

    // Beacon instance: frames at cycles 100, 200, ... after reset release
    rst_b = 1'b0;
    nframes = 0;
    for (int k = 1; k <= 1015; k++) begin
      tick();
      check($sformatf("bcn_valid_k%0d", k), 32'(valid_b),
            32'((k >= 100) && ((k % 100) <= 12)));
      if (k >= 100 && (k % 100) == 0)
        check($sformatf("bcn_sync_k%0d", k), 32'(data_b), 32'hA5);
      if (done_b) nframes++;
    end
    check("bcn_frames", 32'(nframes), 10);
    check("bcn_count", 32'(count_b), 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
